// File: rtl/display_bcd_pager_if.sv
// Display pager bus: channel data and paging controls in, segment drive and status out.
//   ch_data     packed channel values, channel k at [k*WIDTH +: WIDTH]
//   mode        0 = auto page rotation, 1 = manual paging
//   page_step   manual page advance (rising edge)
//   halt_signal freeze paging and blink the display
//   seg_bus     active-low segments, digit d at [7*d +: 7], gfedcba
//   page_idx    channel index of the displayed value
//   busy        conversion in progress
//   overflow    displayed value does not fit in DIGITS digits
interface display_bcd_pager_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3,
    parameter int unsigned NUM_CH = 4
);
    localparam int unsigned PW = $clog2(NUM_CH);

    logic [NUM_CH*WIDTH-1:0] ch_data;
    logic                    mode;
    logic                    page_step;
    logic                    halt_signal;
    logic [7*DIGITS-1:0]     seg_bus;
    logic [PW-1:0]           page_idx;
    logic                    busy;
    logic                    overflow;

    modport master (
        output ch_data, mode, page_step, halt_signal,
        input  seg_bus, page_idx, busy, overflow
    );

    modport slave (
        input  ch_data, mode, page_step, halt_signal,
        output seg_bus, page_idx, busy, overflow
    );
endinterface

// File: rtl/display_bcd_pager.sv
// Multi-channel 7-segment pager: picks one channel per page, converts it to BCD by
// double dabble and drives leading-zero-blanked active-low digits.
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    display_bcd_pager_if slave (channel data, paging controls, display outputs)
module display_bcd_pager #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DWELL  = 50_000_000,
    parameter int unsigned BLINK  = 25_000_000
) (
    input  logic               clk,
    input  logic               reset,
    display_bcd_pager_if.slave bus
);
    localparam int unsigned PW   = $clog2(NUM_CH);
    // (WIDTH+2)/3 BCD digits always hold a WIDTH-bit value since log10(2) < 1/3.
    localparam int unsigned NB   = (WIDTH + 2) / 3;
    localparam int unsigned BN   = (NB > DIGITS) ? NB : DIGITS;
    localparam int unsigned DW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned BW   = (BLINK > 1) ? $clog2(BLINK) : 1;
    localparam int unsigned SW   = $clog2(WIDTH + 1);
    localparam int unsigned SEGW = 7 * DIGITS;

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  sample_q;
    logic [4*BN-1:0]   bcd_q;
    logic [4*BN-1:0]   bcd_adj;
    logic [SW-1:0]     shift_cnt_q;
    logic [PW-1:0]     load_page_q;
    logic [SEGW-1:0]   seg_q;
    logic [SEGW-1:0]   seg_d;
    logic              ovf_d;
    logic [PW-1:0]     page_idx_q;
    logic              busy_q;
    logic              overflow_q;

    logic [PW-1:0]     page_q;
    logic [DW-1:0]     dwell_q;
    logic              step_prev_q;
    logic              mode_prev_q;
    logic [BW-1:0]     blink_cnt_q;
    logic              blink_on_q;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Double-dabble correction applied before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(BN); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Digit encode from the finished BCD value; any nonzero digit beyond DIGITS is overflow.
    always_comb begin
        logic lead;
        seg_d = '1;
        ovf_d = 1'b0;
        lead  = 1'b1;
        for (int i = int'(DIGITS); i < int'(BN); i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                ovf_d = 1'b1;
            end
        end
        for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
            if (ovf_d) begin
                seg_d[7*d +: 7] = 7'b0111111;
            end else if (!lead || d == 0 || bcd_q[4*d +: 4] != 4'd0) begin
                seg_d[7*d +: 7] = glyph(bcd_q[4*d +: 4]);
                lead            = 1'b0;
            end
        end
    end

    // Conversion FSM: continuous LOAD -> SHIFT x WIDTH -> DONE refresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            sample_q    <= '0;
            bcd_q       <= '0;
            shift_cnt_q <= '0;
            load_page_q <= '0;
            seg_q       <= '1;
            page_idx_q  <= '0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q <= StLoad;
                    busy_q  <= 1'b1;
                end
                StLoad: begin
                    sample_q    <= bus.ch_data[page_q*WIDTH +: WIDTH];
                    load_page_q <= page_q;
                    bcd_q       <= '0;
                    shift_cnt_q <= '0;
                    state_q     <= StShift;
                end
                StShift: begin
                    {bcd_q, sample_q} <= {bcd_adj, sample_q} << 1;
                    shift_cnt_q       <= shift_cnt_q + SW'(1);
                    if (shift_cnt_q == SW'(WIDTH - 1)) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                    end
                end
                StDone: begin
                    seg_q      <= seg_d;
                    overflow_q <= ovf_d;
                    page_idx_q <= load_page_q;
                    state_q    <= StLoad;
                    busy_q     <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Page selection. Step/mode history is tracked even while halted so that
    // edges arriving during halt are swallowed rather than replayed afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            page_q      <= '0;
            dwell_q     <= '0;
            step_prev_q <= 1'b0;
            mode_prev_q <= 1'b0;
        end else begin
            step_prev_q <= bus.page_step;
            mode_prev_q <= bus.mode;
            if (!bus.halt_signal) begin
                if (bus.mode != mode_prev_q) begin
                    dwell_q <= '0;
                end else if (!bus.mode) begin
                    if (dwell_q == DW'(DWELL - 1)) begin
                        dwell_q <= '0;
                        page_q  <= page_q + PW'(1);
                    end else begin
                        dwell_q <= dwell_q + DW'(1);
                    end
                end else begin
                    dwell_q <= '0;
                    if (bus.page_step && !step_prev_q) begin
                        page_q <= page_q + PW'(1);
                    end
                end
            end
        end
    end

    // Blink phase while halted; forced back to visible as soon as halt drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else if (!bus.halt_signal) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else if (blink_cnt_q == BW'(BLINK - 1)) begin
            blink_cnt_q <= '0;
            blink_on_q  <= ~blink_on_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BW'(1);
        end
    end

    assign bus.seg_bus  = blink_on_q ? seg_q : '1;
    assign bus.page_idx = page_idx_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = overflow_q;
endmodule

// File: doc/display_bcd_pager.md
DISPLAY_BCD_PAGER -- requirements
Module: display_bcd_pager

Interface
REQ-001 SHALL: WIDTH, 8, bit width of each channel value.
REQ-002 SHALL: DIGITS, 3, number of decimal digits driven (DIGITS >= 2).
REQ-003 SHALL: NUM_CH, 4, number of channels paged (power of two, >= 2).
REQ-004 SHALL: DWELL, 50_000_000, clk cycles each page is shown in auto mode.
REQ-005 SHALL: BLINK, 25_000_000, clk cycles per blink half-period while halted.
REQ-006 SHALL: clk  input  1  single system clock, all state on rising edge.
REQ-007 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL: ch_data  input  NUM_CH*WIDTH  packed channel values, channel k at [k*WIDTH +: WIDTH].
REQ-009 SHALL: mode  input  1  0 = auto page rotation, 1 = manual paging.
REQ-010 SHALL: page_step  input  1  synchronous level; each rising edge advances the page in manual mode.
REQ-011 SHALL: halt_signal  input  1  freezes paging and blinks the display.
REQ-012 SHALL: seg_bus  output  7*DIGITS  active-low segments, digit d (d=0 is ones) at [7*d +: 7], bit order gfedcba.
REQ-013 SHALL: page_idx  output  log2(NUM_CH)  channel index of the value currently displayed.
REQ-014 SHALL: busy  output  1  high while a conversion is in LOAD or SHIFT.
REQ-015 SHALL: overflow  output  1  high when the displayed value is >= 10^DIGITS.

Function
REQ-016 SHALL: FSM states IDLE, LOAD, SHIFT, DONE; IDLE->LOAD 1 cycle after reset release; LOAD->SHIFT; SHIFT->DONE after WIDTH cycles; DONE->LOAD (continuous refresh).
REQ-017 SHALL: in LOAD, sample the channel selected by the internal page register together with that page index, and clear the BCD register.
REQ-018 SHALL: each SHIFT cycle, add 3 to every BCD nibble >= 5, then shift left {bcd, sample} one bit, MSB first (double dabble).
REQ-019 SHALL: seg_bus, page_idx and overflow update only in DONE; conversion latency LOAD-to-output is WIDTH+2 cycles; outputs hold between DONE cycles.
REQ-020 SHALL: digit encoding 0-9 = 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-021 SHALL: leading zeros blanked (1111111) above the most significant nonzero digit; digit 0 always shown (value 0 shows "0").
REQ-022 SHALL: if the sample is >= 10^DIGITS, every digit shows dash 0111111 and overflow=1; otherwise overflow=0.
REQ-023 SHALL: auto mode: dwell counter counts 0..DWELL-1, and on terminal count the page increments, wrapping from NUM_CH-1 to 0.
REQ-024 SHALL: manual mode: the page increments once per detected page_step rising edge (registered previous value); the dwell counter is held at 0.
REQ-025 SHALL: a page change during SHIFT does not disturb the in-flight conversion; the new page is sampled at the next LOAD.
REQ-026 SHALL: a mode change clears the dwell counter and keeps the current page.
REQ-027 SHALL: while halt_signal=1, the page and dwell counter are frozen and page_step edges are ignored; the blink counter toggles the phase every BLINK cycles, and in the off phase seg_bus is all 1s.
REQ-028 SHALL: on halt_signal falling, the blink phase resets to on and the display is visible the next cycle.
REQ-029 SHALL: conversions continue during halt, so a changed value on the frozen page is still refreshed.

Reset
REQ-030 SHALL: on reset assertion, take effect immediately, including mid-SHIFT: state=IDLE, seg_bus all 1s, page_idx=0, page=0, busy=0, overflow=0, all counters 0, blink phase on, page_step history 0.

Verification
REQ-031 SHALL: defaults, ch0=157, release reset -> after WIDTH+3 cycles seg_bus digits 2..0 = 1111001, 0010010, 1111000; page_idx=0.
REQ-032 SHALL: ch0=7 -> digits 2,1 = 1111111, digit 0 = 1111000; ch0=0 -> digit 0 = 1000000.
REQ-033 SHALL: DIGITS=2, ch0=200 -> both digits 0111111, overflow=1; then ch0=99 -> 0010000 0010000, overflow=0 within 2*(WIDTH+2) cycles.
REQ-034 SHALL: DWELL=4, NUM_CH=4, auto, distinct channel values -> page_idx 0,1,2,3,0 with the matching value shown each dwell; manual mode with 3 page_step pulses -> page 3.
REQ-035 SHALL: BLINK=2, halt_signal=1 -> seg_bus alternates blank/value every 2 cycles and page_idx is frozen; on release the display is steady and paging resumes.
REQ-036 SHALL: assert reset at SHIFT cycle 4 -> all outputs at reset values in the same cycle; after release, the first valid output is WIDTH+3 cycles later.
